// File: rtl/brownout_pkg.sv
// Shared types and constants for the brownout macro sequencer.
package brownout_pkg;

  localparam int TRIM_W = 3;
  localparam logic [TRIM_W-1:0] TRIM_RESET = 3'b111;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_MONITOR  = 3'd2,
    ST_BROWNOUT = 3'd3,
    ST_RECOVER  = 3'd4
  } bo_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/brownout_seq_if.sv
// Config/status bus between the register file (master) and the brownout sequencer (slave).
interface brownout_seq_if #(
  parameter int CNT_W = 8
);
  import brownout_pkg::*;

  logic              cfg_ena;
  logic [TRIM_W-1:0] cfg_otrip;
  logic [TRIM_W-1:0] cfg_vtrip;
  logic              cfg_wr;
  logic              clr_status;
  logic              bo_sticky;
  logic              vu_sticky;
  logic [CNT_W-1:0]  evt_cnt;
  logic [2:0]        state_o;

  modport master (
    output cfg_ena, cfg_otrip, cfg_vtrip, cfg_wr, clr_status,
    input  bo_sticky, vu_sticky, evt_cnt, state_o
  );

  modport slave (
    input  cfg_ena, cfg_otrip, cfg_vtrip, cfg_wr, clr_status,
    output bo_sticky, vu_sticky, evt_cnt, state_o
  );

endinterface

// File: rtl/bo_sync.sv
// Multi-flop synchronizer for asynchronous comparator outputs from the analog macro.
module bo_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetb,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/brownout_seq.sv
// Brownout macro sequencer: enable/trim ownership, blanking, debounce, reset-hold, status.
// state    | meaning
// OFF      | macro disabled, reset-hold asserted
// SETTLE   | comparators blanked after enable or trim load
// MONITOR  | armed, reset-hold released, debouncing brout
// BROWNOUT | brownout active, reset-hold asserted
// RECOVER  | brout low, waiting out the hold time
module brownout_seq
  import brownout_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 64,
  parameter int DEB_CYC     = 4,
  parameter int HOLD_CYC    = 1024,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              resetb,
  brownout_seq_if.slave     bus,
  input  logic              brout_in,
  input  logic              vunder_in,
  output logic              ana_ena,
  output logic [TRIM_W-1:0] ana_otrip,
  output logic [TRIM_W-1:0] ana_vtrip,
  output logic              por_hold
);

  localparam int TMR_W = $clog2(max_int(SETTLE_CYC, HOLD_CYC)) + 1;
  localparam int DEB_W = $clog2(DEB_CYC) + 1;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYC - 1);
  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYC - 1);

  bo_state_e         r_state;
  bo_state_e         w_state_nxt;
  logic [TMR_W-1:0]  r_tmr;
  logic [TMR_W-1:0]  w_tmr_nxt;
  logic [DEB_W-1:0]  r_deb;
  logic [DEB_W-1:0]  w_deb_nxt;
  logic              r_pend;
  logic              w_pend_nxt;
  logic              w_load;
  logic              w_event;
  logic [TRIM_W-1:0] r_shadow_o;
  logic [TRIM_W-1:0] r_shadow_v;
  logic [TRIM_W-1:0] w_shadow_o_nxt;
  logic [TRIM_W-1:0] w_shadow_v_nxt;
  logic              r_ana_ena;
  logic [TRIM_W-1:0] r_ana_otrip;
  logic [TRIM_W-1:0] r_ana_vtrip;
  logic              r_por_hold;
  logic              r_bo;
  logic              r_vu;
  logic [CNT_W-1:0]  r_evt;
  logic [CNT_W-1:0]  w_evt_nxt;
  logic              w_vu_set;
  logic              w_brout;
  logic              w_vunder;
  logic              w_cfg_ena;
  logic              w_cfg_wr;
  logic              w_clr;

  bo_sync #(.STAGES(SYNC_STAGES)) u_sync_brout (
    .clk     (clk),
    .resetb  (resetb),
    .i_async (brout_in),
    .o_sync  (w_brout)
  );

  bo_sync #(.STAGES(SYNC_STAGES)) u_sync_vunder (
    .clk     (clk),
    .resetb  (resetb),
    .i_async (vunder_in),
    .o_sync  (w_vunder)
  );

  assign w_cfg_ena      = bus.cfg_ena;
  assign w_cfg_wr       = bus.cfg_wr;
  assign w_clr          = bus.clr_status;
  assign w_shadow_o_nxt = w_cfg_wr ? bus.cfg_otrip : r_shadow_o;
  assign w_shadow_v_nxt = w_cfg_wr ? bus.cfg_vtrip : r_shadow_v;

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_deb_nxt   = '0;
    w_pend_nxt  = r_pend;
    w_load      = 1'b0;
    w_event     = 1'b0;
    if (!w_cfg_ena) begin
      w_state_nxt = ST_OFF;
      w_pend_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        ST_OFF: begin
          w_state_nxt = ST_SETTLE;
          w_load      = 1'b1;
          w_tmr_nxt   = '0;
          w_pend_nxt  = 1'b0;
        end
        ST_SETTLE: begin
          if (w_cfg_wr) begin
            w_load    = 1'b1;
            w_tmr_nxt = '0;
          end else if (r_tmr == SETTLE_LAST) begin
            w_state_nxt = w_brout ? ST_BROWNOUT : ST_MONITOR;
            w_tmr_nxt   = '0;
          end else begin
            w_tmr_nxt = r_tmr + TMR_W'(1);
          end
        end
        ST_MONITOR: begin
          // A debounced brownout outranks a trim write; the write is then pended.
          if (w_brout && (r_deb == DEB_LAST)) begin
            w_state_nxt = ST_BROWNOUT;
            w_event     = 1'b1;
            w_pend_nxt  = r_pend | w_cfg_wr;
          end else if (w_cfg_wr) begin
            w_state_nxt = ST_SETTLE;
            w_load      = 1'b1;
            w_tmr_nxt   = '0;
          end else if (w_brout) begin
            w_deb_nxt = r_deb + DEB_W'(1);
          end
        end
        ST_BROWNOUT: begin
          if (w_cfg_wr) w_pend_nxt = 1'b1;
          if (!w_brout) begin
            w_state_nxt = ST_RECOVER;
            w_tmr_nxt   = '0;
          end
        end
        ST_RECOVER: begin
          if (w_cfg_wr) w_pend_nxt = 1'b1;
          if (w_brout) begin
            w_state_nxt = ST_BROWNOUT;
          end else if (r_tmr == HOLD_LAST) begin
            w_state_nxt = ST_MONITOR;
          end else begin
            w_tmr_nxt = r_tmr + TMR_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
        end
      endcase
      // A pended trim is applied on the way back into MONITOR, which re-blanks instead.
      if ((w_state_nxt == ST_MONITOR) && w_pend_nxt) begin
        w_state_nxt = ST_SETTLE;
        w_load      = 1'b1;
        w_tmr_nxt   = '0;
        w_pend_nxt  = 1'b0;
      end
    end
  end

  assign w_vu_set = w_vunder && (r_state inside {ST_MONITOR, ST_BROWNOUT, ST_RECOVER});

  always_comb begin
    w_evt_nxt = r_evt;
    if (w_event) begin
      if (w_clr) begin
        w_evt_nxt = CNT_W'(1);
      end else if (r_evt != '1) begin
        w_evt_nxt = r_evt + CNT_W'(1);
      end
    end else if (w_clr) begin
      w_evt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state     <= ST_OFF;
      r_tmr       <= '0;
      r_deb       <= '0;
      r_pend      <= 1'b0;
      r_shadow_o  <= TRIM_RESET;
      r_shadow_v  <= TRIM_RESET;
      r_ana_ena   <= 1'b0;
      r_ana_otrip <= TRIM_RESET;
      r_ana_vtrip <= TRIM_RESET;
      r_por_hold  <= 1'b1;
      r_bo        <= 1'b0;
      r_vu        <= 1'b0;
      r_evt       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tmr      <= w_tmr_nxt;
      r_deb      <= w_deb_nxt;
      r_pend     <= w_pend_nxt;
      r_shadow_o <= w_shadow_o_nxt;
      r_shadow_v <= w_shadow_v_nxt;
      r_ana_ena  <= (w_state_nxt != ST_OFF);
      r_por_hold <= (w_state_nxt != ST_MONITOR);
      if (w_load) begin
        r_ana_otrip <= w_shadow_o_nxt;
        r_ana_vtrip <= w_shadow_v_nxt;
      end
      if (w_event) begin
        r_bo <= 1'b1;
      end else if (w_clr) begin
        r_bo <= 1'b0;
      end
      if (w_vu_set) begin
        r_vu <= 1'b1;
      end else if (w_clr) begin
        r_vu <= 1'b0;
      end
      r_evt <= w_evt_nxt;
    end
  end

  assign ana_ena       = r_ana_ena;
  assign ana_otrip     = r_ana_otrip;
  assign ana_vtrip     = r_ana_vtrip;
  assign por_hold      = r_por_hold;
  assign bus.bo_sticky = r_bo;
  assign bus.vu_sticky = r_vu;
  assign bus.evt_cnt   = r_evt;
  assign bus.state_o   = r_state;

endmodule

// File: tb/tb_brownout_seq.sv
// Scoreboard bench for brownout_seq: expectations queued at stimulus time, popped on observation.
module tb_brownout_seq;
  import brownout_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int SETTLE_CYC  = 64;
  localparam int DEB_CYC     = 4;
  localparam int HOLD_CYC    = 1024;
  localparam int CNT_W       = 8;

  logic              clk       = 1'b0;
  logic              resetb    = 1'b1;
  logic              brout_in  = 1'b0;
  logic              vunder_in = 1'b0;
  logic              ana_ena;
  logic              por_hold;
  logic [TRIM_W-1:0] ana_otrip;
  logic [TRIM_W-1:0] ana_vtrip;

  brownout_seq_if #(.CNT_W(CNT_W)) bus ();

  brownout_seq #(
    .SYNC_STAGES (SYNC_STAGES),
    .SETTLE_CYC  (SETTLE_CYC),
    .DEB_CYC     (DEB_CYC),
    .HOLD_CYC    (HOLD_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .resetb    (resetb),
    .bus       (bus.slave),
    .brout_in  (brout_in),
    .vunder_in (vunder_in),
    .ana_ena   (ana_ena),
    .ana_otrip (ana_otrip),
    .ana_vtrip (ana_vtrip),
    .por_hold  (por_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t        sb_q[$];
  int               n_vec  = 0;
  int               n_miss = 0;
  logic [CNT_W-1:0] m_evt;
  logic             m_bo;
  logic [2:0]       m_otrip;
  logic [2:0]       m_vtrip;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    sb_entry_t e;
    e = sb_q.pop_front();
    chk(e.tag, obs, e.exp);
  endtask

  task automatic expect_status(input string pfx, input logic ena, input logic [2:0] otrip,
                               input logic por, input logic bo, input logic [CNT_W-1:0] evt,
                               input bo_state_e st);
    sb_push({pfx, "_ana_ena"}, 32'(ena));
    sb_push({pfx, "_ana_otrip"}, 32'(otrip));
    sb_push({pfx, "_por_hold"}, 32'(por));
    sb_push({pfx, "_bo_sticky"}, 32'(bo));
    sb_push({pfx, "_evt_cnt"}, 32'(evt));
    sb_push({pfx, "_state"}, 32'(st));
  endtask

  task automatic check_status();
    sb_pop(32'(ana_ena));
    sb_pop(32'(ana_otrip));
    sb_pop(32'(por_hold));
    sb_pop(32'(bus.bo_sticky));
    sb_pop(32'(bus.evt_cnt));
    sb_pop(32'(bus.state_o));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input bo_state_e s, input int budget, output int cyc);
    cyc = 0;
    while ((bus.state_o != s) && (cyc < budget)) begin
      step(1);
      cyc++;
    end
    if (bus.state_o != s) chk("wait_state_timeout", 32'(bus.state_o), 32'(s));
  endtask

  task automatic wr_trim(input logic [2:0] o, input logic [2:0] v);
    bus.cfg_otrip = o;
    bus.cfg_vtrip = v;
    bus.cfg_wr    = 1'b1;
    step(1);
    bus.cfg_wr    = 1'b0;
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc;
    bus.cfg_ena    = 1'b0;
    bus.cfg_otrip  = 3'b111;
    bus.cfg_vtrip  = 3'b111;
    bus.cfg_wr     = 1'b0;
    bus.clr_status = 1'b0;
    m_evt   = '0;
    m_bo    = 1'b0;
    m_otrip = 3'b111;
    m_vtrip = 3'b111;

    // reset values
    expect_status("rst", 1'b0, 3'b111, 1'b1, 1'b0, '0, ST_OFF);
    sb_push("rst_ana_vtrip", 32'h7);
    sb_push("rst_vu_sticky", 32'h0);
    #2 resetb = 1'b0;
    step(2);
    check_status();
    sb_pop(32'(ana_vtrip));
    sb_pop(32'(bus.vu_sticky));

    // power-up: ana_ena on the first edge, hold released SETTLE_CYC+1 edges after cfg_ena
    sb_push("pu_ana_ena_first", 32'h1);
    sb_push("pu_state_first", 32'(ST_SETTLE));
    sb_push("pu_hold_latency", 32'(SETTLE_CYC + 1));
    expect_status("pu", 1'b1, m_otrip, 1'b0, 1'b0, '0, ST_MONITOR);
    resetb      = 1'b1;
    bus.cfg_ena = 1'b1;
    step(1);
    cyc = 1;
    sb_pop(32'(ana_ena));
    sb_pop(32'(bus.state_o));
    while (por_hold && (cyc < 200)) begin
      step(1);
      cyc++;
    end
    sb_pop(32'(cyc));
    check_status();

    // glitch of DEB_CYC-1 cycles is rejected
    expect_status("glitch", 1'b1, m_otrip, 1'b0, 1'b0, '0, ST_MONITOR);
    brout_in = 1'b1;
    step(DEB_CYC - 1);
    brout_in = 1'b0;
    step(10);
    check_status();

    // brownout, re-pulse in RECOVER, then release after HOLD_CYC
    m_evt = sat_inc(m_evt);
    m_bo  = 1'b1;
    expect_status("bo", 1'b1, m_otrip, 1'b1, m_bo, m_evt, ST_BROWNOUT);
    brout_in = 1'b1;
    step(10);
    check_status();
    brout_in = 1'b0;
    wait_state(ST_RECOVER, 20, cyc);
    step(499);
    sb_push("rec_repulse_state", 32'(ST_BROWNOUT));
    expect_status("rebo", 1'b1, m_otrip, 1'b1, m_bo, m_evt, ST_BROWNOUT);
    brout_in = 1'b1;
    wait_state(ST_BROWNOUT, 10, cyc);
    sb_pop(32'(bus.state_o));
    step(3);
    check_status();
    brout_in = 1'b0;
    wait_state(ST_RECOVER, 20, cyc);
    sb_push("rec_hold_len", 32'(HOLD_CYC));
    expect_status("rel", 1'b1, m_otrip, 1'b0, m_bo, m_evt, ST_MONITOR);
    cyc = 0;
    while (por_hold && (cyc < HOLD_CYC + 50)) begin
      step(1);
      cyc++;
    end
    sb_pop(32'(cyc));
    check_status();

    // trim write in MONITOR: immediate load, SETTLE_CYC of blanking, no event
    m_otrip = 3'b010;
    m_vtrip = 3'b011;
    sb_push("trim_otrip", 32'(m_otrip));
    sb_push("trim_vtrip", 32'(m_vtrip));
    sb_push("trim_state", 32'(ST_SETTLE));
    sb_push("trim_settle_len", 32'(SETTLE_CYC));
    expect_status("trim_done", 1'b1, m_otrip, 1'b0, m_bo, m_evt, ST_MONITOR);
    wr_trim(3'b010, 3'b011);
    sb_pop(32'(ana_otrip));
    sb_pop(32'(ana_vtrip));
    sb_pop(32'(bus.state_o));
    cyc = 0;
    while ((bus.state_o != ST_MONITOR) && (cyc < 200)) begin
      step(1);
      cyc++;
    end
    sb_pop(32'(cyc));
    check_status();

    // trim write during BROWNOUT is pended until recovery, then SETTLE
    m_evt = sat_inc(m_evt);
    brout_in = 1'b1;
    wait_state(ST_BROWNOUT, 20, cyc);
    sb_push("pend_hold_bo", 32'(m_otrip));
    sb_push("pend_hold_rec", 32'(m_otrip));
    wr_trim(3'b101, 3'b011);
    sb_pop(32'(ana_otrip));
    brout_in = 1'b0;
    wait_state(ST_RECOVER, 20, cyc);
    sb_pop(32'(ana_otrip));
    m_otrip = 3'b101;
    sb_push("pend_exit_state", 32'(ST_SETTLE));
    sb_push("pend_exit_otrip", 32'(m_otrip));
    expect_status("pend_done", 1'b1, m_otrip, 1'b0, m_bo, m_evt, ST_MONITOR);
    cyc = 0;
    while ((bus.state_o == ST_RECOVER) && (cyc < HOLD_CYC + 20)) begin
      step(1);
      cyc++;
    end
    sb_pop(32'(bus.state_o));
    sb_pop(32'(ana_otrip));
    wait_state(ST_MONITOR, 100, cyc);
    check_status();

    // vunder sticky, clear vs simultaneous set
    sb_push("vu_set", 32'h1);
    sb_push("vu_clr_set_wins", 32'h1);
    sb_push("clr_bo", 32'h0);
    sb_push("clr_evt", 32'h0);
    sb_push("vu_cleared", 32'h0);
    vunder_in = 1'b1;
    step(4);
    sb_pop(32'(bus.vu_sticky));
    bus.clr_status = 1'b1;
    step(1);
    bus.clr_status = 1'b0;
    m_evt = '0;
    m_bo  = 1'b0;
    sb_pop(32'(bus.vu_sticky));
    sb_pop(32'(bus.bo_sticky));
    sb_pop(32'(bus.evt_cnt));
    vunder_in = 1'b0;
    step(4);
    bus.clr_status = 1'b1;
    step(1);
    bus.clr_status = 1'b0;
    sb_pop(32'(bus.vu_sticky));

    // event counter saturates
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      m_evt = sat_inc(m_evt);
      m_bo  = 1'b1;
      brout_in = 1'b1;
      wait_state(ST_BROWNOUT, 20, cyc);
      brout_in    = 1'b0;
      bus.cfg_ena = 1'b0;
      step(1);
      bus.cfg_ena = 1'b1;
      wait_state(ST_MONITOR, 200, cyc);
    end
    expect_status("sat", 1'b1, m_otrip, 1'b0, m_bo, m_evt, ST_MONITOR);
    check_status();

    // clear coinciding with an event: count restarts at one, sticky stays set
    m_evt = CNT_W'(1);
    m_bo  = 1'b1;
    expect_status("clr_on_evt", 1'b1, m_otrip, 1'b1, m_bo, m_evt, ST_BROWNOUT);
    brout_in = 1'b1;
    step(DEB_CYC + SYNC_STAGES - 1);
    bus.clr_status = 1'b1;
    step(1);
    bus.clr_status = 1'b0;
    check_status();

    // disable mid-RECOVER
    brout_in = 1'b0;
    wait_state(ST_RECOVER, 20, cyc);
    step(100);
    expect_status("dis", 1'b0, m_otrip, 1'b1, m_bo, m_evt, ST_OFF);
    bus.cfg_ena = 1'b0;
    step(1);
    check_status();

    // async reset mid-SETTLE, observed before any further clock edge
    sb_push("rs_pre_state", 32'(ST_SETTLE));
    expect_status("rst_mid", 1'b0, 3'b111, 1'b1, 1'b0, '0, ST_OFF);
    sb_push("rst_mid_vtrip", 32'h7);
    bus.cfg_ena = 1'b1;
    step(10);
    sb_pop(32'(bus.state_o));
    #2 resetb = 1'b0;
    #1;
    check_status();
    sb_pop(32'(ana_vtrip));

    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
